// File: rtl/audio_avg_filter.sv
// Streaming moving-average low-pass filter with a runtime power-of-two window.
// A circular history buffer and a running sum give one sample per cycle; history is zeroed on (re)start.
module audio_avg_filter #(
  parameter int DATA_W   = 8,
  parameter int MAX_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        win_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** MAX_LOG2;
  localparam int SUM_W = DATA_W + MAX_LOG2;
  localparam int K_W   = (MAX_LOG2 < 1) ? 1 : $clog2(MAX_LOG2 + 1);
  localparam logic [MAX_LOG2-1:0] LAST_IDX = MAX_LOG2'(DEPTH - 1);
  localparam logic [MAX_LOG2-1:0] IDX_ONE  = MAX_LOG2'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic [MAX_LOG2-1:0]  clrCnt;
  logic [MAX_LOG2-1:0]  wptr;
  logic [MAX_LOG2-1:0]  oldIdx;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sumNext;
  logic [K_W-1:0]       kR;
  logic [K_W-1:0]       kSel;
  logic [DATA_W-1:0]    hist [DEPTH];
  logic [DATA_W-1:0]    oldSample;
  logic                 winChanged;
  logic                 accept;
  logic                 xfer;

  // Requested window is clamped to the history depth.
  assign kSel       = (win_sel > 4'(MAX_LOG2)) ? K_W'(MAX_LOG2) : K_W'(win_sel);
  assign winChanged = (kSel != kR);
  assign in_ready   = (state == RUN) && !winChanged && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign busy       = (state == CLEAR);

  // The entry leaving the window sits W slots behind the write pointer; W == DEPTH wraps onto wptr itself.
  assign oldIdx     = wptr - MAX_LOG2'(32'd1 << kR);
  assign oldSample  = hist[oldIdx];
  assign sumNext    = sum + SUM_W'(in_data) - SUM_W'(oldSample);

  // Next-state selection: clear sweeps the whole buffer, a window change restarts it.
  always_comb begin
    stateNext = state;
    case (state)
      CLEAR: begin
        if (clrCnt == LAST_IDX) begin
          stateNext = RUN;
        end else begin
          stateNext = CLEAR;
        end
      end
      RUN: begin
        if (winChanged) begin
          stateNext = CLEAR;
        end else begin
          stateNext = RUN;
        end
      end
      default: stateNext = CLEAR;
    endcase
  end

  // Control, running sum and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clrCnt    <= '0;
      wptr      <= '0;
      sum       <= '0;
      kR        <= kSel;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= stateNext;
      case (state)
        CLEAR: begin
          clrCnt <= clrCnt + IDX_ONE;
          sum    <= '0;
          wptr   <= '0;
        end
        RUN: begin
          if (winChanged) begin
            clrCnt <= '0;
            kR     <= kSel;
          end else if (accept) begin
            sum  <= sumNext;
            wptr <= wptr + IDX_ONE;
          end else begin
            sum  <= sum;
            wptr <= wptr;
          end
        end
        default: begin
          clrCnt <= '0;
        end
      endcase

      // A pending result survives a window change until the consumer takes it.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= DATA_W'(sumNext >> kR);
      end else if (xfer) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

  // History buffer: zero sweep while clearing, sample write on accept.
  always_ff @(posedge clk) begin
    if (rst_n && (state == CLEAR)) begin
      hist[clrCnt] <= '0;
    end else if (rst_n && accept) begin
      hist[wptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Randomised scoreboard bench for audio_avg_filter; a queue-based moving-average
// model predicts each output, and a monitor compares on every output transfer.
module tb_audio_avg_filter;

  localparam int DATA_W   = 8;
  localparam int MAX_LOG2 = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        win_sel = 4'd2;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  audio_avg_filter #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .win_sel(win_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int   nVec = 0;
  int   nErr = 0;
  int   expQ[$];
  int   histQ[$];
  int   kModel = 0;
  logic lastAcc = 1'b0;
  logic stallValid = 1'b0;
  int   stallData = 0;

  task automatic check(input string name, input int act, input int req);
    nVec++;
    if (act != req) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int effK(input logic [3:0] s);
    return (int'(s) > MAX_LOG2) ? MAX_LOG2 : int'(s);
  endfunction

  // Window restarts as W zeros, so early outputs average against zero padding.
  task automatic modelClear(input int k);
    kModel = k;
    histQ.delete();
    for (int i = 0; i < (1 << k); i++) histQ.push_back(0);
  endtask

  task automatic modelPush(input int x, output int e);
    int s = 0;
    histQ.push_back(x);
    if (histQ.size() > (1 << kModel)) void'(histQ.pop_front());
    foreach (histQ[i]) s += histQ[i];
    e = s >> kModel;
  endtask

  // One cycle of stimulus: drive at the falling edge, decide acceptance just after.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                      input logic [3:0] ws, output logic acc);
    int e;
    @(negedge clk);
    if (lastAcc) check("latency out_valid", int'(out_valid), 1);
    win_sel   = ws;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc     = in_valid && in_ready;
    lastAcc = acc;
    if (acc) begin
      modelPush(int'(d), e);
      expQ.push_back(e);
    end
    if (effK(ws) != kModel) modelClear(effK(ws));
  endtask

  task automatic setWindow(input logic [3:0] ws);
    logic acc;
    int   n;
    step(1'b0, 8'd0, 1'b1, ws, acc);
    n = 0;
    do begin
      step(1'b0, 8'd0, 1'b1, ws, acc);
      n++;
    end while (busy && n < 40);
    if (busy) check("clear timeout busy", int'(busy), 0);
  endtask

  task automatic pulseReset(input int cycles, input logic [3:0] ws);
    @(negedge clk);
    rst_n      = 1'b0;
    win_sel    = ws;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    expQ.delete();
    stallValid = 1'b0;
    lastAcc    = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    modelClear(effK(ws));
  endtask

  // Monitor: compares every output transfer against the scoreboard and checks hold-under-stall.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n || !out_valid) begin
        stallValid = 1'b0;
      end else begin
        if (stallValid) check("stall hold out_data", int'(out_data), stallData);
        if (out_ready) begin
          if (expQ.size() == 0) begin
            nVec++;
            nErr++;
            $display("FAIL spurious output: got %0d with nothing expected (t=%0t)", out_data, $time);
          end else begin
            check("scoreboard out_data", int'(out_data), expQ.pop_front());
          end
          stallValid = 1'b0;
        end else begin
          stallValid = 1'b1;
          stallData  = int'(out_data);
        end
      end
    end
  end

  initial begin
    logic acc;
    int   cnt;
    int   ks[5] = '{3, 1, 4, 0, 2};

    // Reset and initial clear sweep
    pulseReset(3, 4'd2);
    #1;
    check("reset out_data", int'(out_data), 0);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt <= 2) begin
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
      end
      @(negedge clk);
      #1;
    end
    check("reset busy cycles", cnt, 16);
    step(1'b0, 8'd0, 1'b1, 4'd2, acc);
    check("post-clear busy", int'(busy), 0);
    check("post-clear in_ready", int'(in_ready), 1);

    // Ramp with W=4
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'd8, 1'b1, 4'd2, acc);
      check("ramp accept", int'(acc), 1);
    end
    step(1'b0, 8'd0, 1'b1, 4'd2, acc);

    // Bypass with W=1
    setWindow(4'd0);
    step(1'b1, 8'h7F, 1'b1, 4'd0, acc);
    check("bypass in_ready 0", int'(in_ready), 1);
    step(1'b1, 8'h00, 1'b1, 4'd0, acc);
    check("bypass in_ready 1", int'(in_ready), 1);
    check("bypass out 7F", int'(out_data), 127);
    step(1'b0, 8'd0, 1'b1, 4'd0, acc);
    check("bypass out 00", int'(out_data), 0);

    // Backpressure with W=4
    setWindow(4'd2);
    step(1'b1, 8'd4, 1'b0, 4'd2, acc);
    check("bp first accept", int'(acc), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'd12, 1'b0, 4'd2, acc);
      check("bp stalled accept", int'(acc), 0);
      check("bp out_valid", int'(out_valid), 1);
      check("bp out_data", int'(out_data), 1);
      check("bp in_ready", int'(in_ready), 0);
    end
    step(1'b1, 8'd12, 1'b1, 4'd2, acc);
    check("bp resume accept", int'(acc), 1);
    step(1'b0, 8'd0, 1'b1, 4'd2, acc);
    check("bp next out_data", int'(out_data), 4);

    // Window change with a pending output, then clamped W=16
    step(1'b1, 8'd100, 1'b0, 4'd2, acc);
    step(1'b0, 8'd0, 1'b0, 4'd15, acc);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'd0, (cnt >= 3), 4'd15, acc);
      if (!busy) break;
      if (cnt < 3) check("clear keeps out_valid", int'(out_valid), 1);
      cnt++;
    end
    check("winchange busy cycles", cnt, 16);
    check("winchange pending delivered", int'(expQ.size()), 0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'd255, 1'b1, 4'd15, acc);
      check("w16 accept", int'(acc), 1);
    end
    step(1'b0, 8'd0, 1'b1, 4'd15, acc);
    check("w16 wrapped out_data", int'(out_data), 255);

    // Randomised traffic over several windows with random backpressure
    foreach (ks[j]) begin
      setWindow(4'(ks[j]));
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0),
             4'(ks[j]), acc);
      end
    end

    // Reset mid-stream with a stalled output
    setWindow(4'd2);
    step(1'b1, 8'd200, 1'b0, 4'd2, acc);
    step(1'b0, 8'd0, 1'b0, 4'd2, acc);
    check("pre-reset out_valid", int'(out_valid), 1);
    pulseReset(1, 4'd2);
    #1;
    check("mid reset out_valid", int'(out_valid), 0);
    check("mid reset busy", int'(busy), 1);
    cnt = 0;
    while (busy && cnt < 40) begin
      step(1'b0, 8'd0, 1'b1, 4'd2, acc);
      cnt++;
    end
    check("mid reset clear cycles", cnt, 16);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd8, 1'b1, 4'd2, acc);
    step(1'b0, 8'd0, 1'b1, 4'd2, acc);
    check("mid reset ramp end", int'(out_data), 8);

    repeat (4) step(1'b0, 8'd0, 1'b1, 4'd2, acc);
    check("scoreboard drained", int'(expQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
